noc_control_module_pkt_rx: RTL and testbench

NOC_CONTROL_MODULE_PKT_RX -- requirements
Module: noc_control_module_pkt_rx

---
 rtl/noc_control_module_pkt_rx_if.sv | 28 ++
 rtl/noc_control_module_pkt_rx.sv | 114 +++++++++++
 tb/tb_noc_control_module_pkt_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_control_module_pkt_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_control_module_pkt_rx_if                                         |
// | DII flit input, fault-injection command output and status counters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface noc_control_module_pkt_rx_if;
  logic        debug_in_valid;
  logic        debug_in_last;
  logic [15:0] debug_in_data;
  logic        debug_in_ready;
  logic        fi_valid;
  logic        fi_last;
  logic [15:0] fi_data;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;

  // slave: the packet receiver; master: the debug ring / FI stage side
  modport slave (
    input  debug_in_valid, debug_in_last, debug_in_data,
    output debug_in_ready, fi_valid, fi_last, fi_data, cnt_ok, cnt_err
  );
  modport master (
    output debug_in_valid, debug_in_last, debug_in_data,
    input  debug_in_ready, fi_valid, fi_last, fi_data, cnt_ok, cnt_err
  );
endinterface
`default_nettype wire

// File: rtl/noc_control_module_pkt_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_control_module_pkt_rx                                            |
// | Parses DII packets and forwards well-formed fault-injection commands. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module noc_control_module_pkt_rx #(
  parameter int         X           = 3,
  parameter int         Y           = 3,
  parameter logic [3:0] FI_TYPE_SUB = 4'hA
) (
  input  logic                        clk,
  input  logic                        rst,
  noc_control_module_pkt_rx_if.slave  bus
);

  localparam int NODES = X * Y;

  localparam logic [2:0] C_HDR_DEST  = 3'd0;
  localparam logic [2:0] C_HDR_SRC   = 3'd1;
  localparam logic [2:0] C_HDR_FLAGS = 3'd2;
  localparam logic [2:0] C_PAYLOAD   = 3'd3;
  localparam logic [2:0] C_DISCARD   = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [1:0]  r_pcnt;
  logic [15:0] r_word;
  logic        r_fi_valid;
  logic [15:0] r_fi_data;
  logic [15:0] r_cnt_ok;
  logic [15:0] r_cnt_err;

  logic        w_xfer;
  logic        w_is_fi;
  logic [15:0] w_word;
  logic        w_node_ok;
  logic        w_emit;
  logic        w_err;

  assign w_xfer  = bus.debug_in_valid && !rst;
  assign w_is_fi = (bus.debug_in_data[15:14] == 2'b10) &&
                   (bus.debug_in_data[13:10] == FI_TYPE_SUB);

  // The first payload word is the command; with no earlier capture it is the current flit
  assign w_word    = (r_pcnt == 2'd0) ? bus.debug_in_data : r_word;
  assign w_node_ok = (int'({24'd0, w_word[15:8]}) < NODES);

  always_ff @(posedge clk) begin
    if (rst) r_state <= C_HDR_DEST;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_xfer) begin
      case (r_state)
        C_HDR_DEST:  w_next = bus.debug_in_last ? C_HDR_DEST : C_HDR_SRC;
        C_HDR_SRC:   w_next = bus.debug_in_last ? C_HDR_DEST : C_HDR_FLAGS;
        C_HDR_FLAGS: begin
          if (bus.debug_in_last) w_next = C_HDR_DEST;
          else if (w_is_fi)      w_next = C_PAYLOAD;
          else                   w_next = C_DISCARD;
        end
        C_PAYLOAD,
        C_DISCARD:   w_next = bus.debug_in_last ? C_HDR_DEST : r_state;
        default:     w_next = C_HDR_DEST;
      endcase
    end
  end

  always_comb begin
    w_emit = 1'b0;
    w_err  = 1'b0;
    if (w_xfer && (r_state == C_PAYLOAD) && bus.debug_in_last) begin
      if ((r_pcnt == 2'd0) && w_node_ok) w_emit = 1'b1;
      else                               w_err  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt     <= 2'd0;
      r_word     <= 16'd0;
      r_fi_valid <= 1'b0;
      r_fi_data  <= 16'd0;
      r_cnt_ok   <= 16'd0;
      r_cnt_err  <= 16'd0;
    end else begin
      r_fi_valid <= w_emit;
      if (w_emit) r_fi_data <= w_word;
      if (w_emit && (r_cnt_ok != 16'hFFFF))  r_cnt_ok  <= r_cnt_ok + 16'd1;
      if (w_err  && (r_cnt_err != 16'hFFFF)) r_cnt_err <= r_cnt_err + 16'd1;
      if (w_xfer) begin
        if (r_state == C_HDR_FLAGS) begin
          r_pcnt <= 2'd0;
        end else if (r_state == C_PAYLOAD) begin
          if (r_pcnt == 2'd0) r_word <= bus.debug_in_data;
          if (r_pcnt != 2'd2) r_pcnt <= r_pcnt + 2'd1;
        end
      end
    end
  end

  // Outputs are masked while rst is high so a pulse already registered never escapes
  assign bus.debug_in_ready = !rst;
  assign bus.fi_valid       = r_fi_valid && !rst;
  assign bus.fi_last        = r_fi_valid && !rst;
  assign bus.fi_data        = rst ? 16'd0 : r_fi_data;
  assign bus.cnt_ok         = r_cnt_ok;
  assign bus.cnt_err        = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_control_module_pkt_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_noc_control_module_pkt_rx                                         |
// | Directed stimulus with a queue of expected fault-injection commands. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_noc_control_module_pkt_rx;

  localparam logic [15:0] C_FLAGS_FI  = 16'hA800;
  localparam logic [15:0] C_FLAGS_REG = 16'h0000;
  localparam int          C_NODES     = 9;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_ok = 16'd0;
  logic [15:0] exp_err = 16'd0;
  exp_t sb[$];

  noc_control_module_pkt_rx_if bus ();

  noc_control_module_pkt_rx #(
    .X(3), .Y(3), .FI_TYPE_SUB(4'hA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every output pulse must match the oldest expected command
  always @(negedge clk) begin
    if (bus.fi_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed=%h expected=none", bus.fi_data);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_data", bus.fi_data, e.d);
        chk("pulse_last", {15'd0, bus.fi_last}, 16'd1);
        chk("pulse_cycle", 16'(cyc), 16'(e.c));
      end
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic put(input logic [15:0] d, input logic l);
    @(negedge clk);
    bus.debug_in_valid = 1'b1;
    bus.debug_in_last  = l;
    bus.debug_in_data  = d;
  endtask

  task automatic send_pkt(input logic [15:0] flags, input int npay,
                          input logic [15:0] p0, input logic [15:0] p1,
                          input logic [15:0] p2, input bit model);
    logic [15:0] pw [3];
    pw[0] = p0; pw[1] = p1; pw[2] = p2;
    put(16'h0011, 1'b0);
    put(16'h0022, 1'b0);
    put(flags, npay == 0);
    for (int i = 0; i < npay; i++) put(pw[i], i == npay - 1);
    if (model && flags[15:14] == 2'b10 && flags[13:10] == 4'hA && npay > 0) begin
      if (npay == 1 && int'(p0[15:8]) < C_NODES) begin
        sb.push_back('{d: p0, c: cyc + 1});
        exp_ok = sat_inc(exp_ok);
      end else begin
        exp_err = sat_inc(exp_err);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.debug_in_valid = 1'b0;
    bus.debug_in_last  = 1'b0;
  endtask

  task automatic settle(input string tag);
    idle();
    @(negedge clk);
    chk({tag, "_cnt_ok"}, bus.cnt_ok, exp_ok);
    chk({tag, "_cnt_err"}, bus.cnt_err, exp_err);
    chk({tag, "_pending"}, 16'(sb.size()), 16'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.debug_in_valid = 1'b0;
    bus.debug_in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_ready"}, {15'd0, bus.debug_in_ready}, 16'd0);
    chk({tag, "_valid"}, {15'd0, bus.fi_valid}, 16'd0);
    chk({tag, "_data"}, bus.fi_data, 16'd0);
    chk({tag, "_cnt_ok"}, bus.cnt_ok, 16'd0);
    chk({tag, "_cnt_err"}, bus.cnt_err, 16'd0);
    rst = 1'b0;
    exp_ok = 16'd0;
    exp_err = 16'd0;
    sb.delete();
    @(negedge clk);
    chk({tag, "_ready_after"}, {15'd0, bus.debug_in_ready}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.debug_in_valid = 1'b0;
    bus.debug_in_last  = 1'b0;
    bus.debug_in_data  = 16'd0;

    do_reset("reset");

    // Single valid command, then the data must hold once the pulse is gone
    send_pkt(C_FLAGS_FI, 1, 16'h0403, 16'h0, 16'h0, 1'b1);
    settle("fi_ok");
    chk("fi_hold_data", bus.fi_data, 16'h0403);
    chk("fi_hold_valid", {15'd0, bus.fi_valid}, 16'd0);

    // Node out of range
    send_pkt(C_FLAGS_FI, 1, 16'h0901, 16'h0, 16'h0, 1'b1);
    settle("bad_node");

    // Two payload words is an error; last on flags is a silent short packet
    send_pkt(C_FLAGS_FI, 2, 16'h0101, 16'h0102, 16'h0, 1'b1);
    settle("two_words");
    send_pkt(C_FLAGS_FI, 0, 16'h0, 16'h0, 16'h0, 1'b1);
    settle("zero_words");

    // Register packet followed back-to-back by an FI command
    do_reset("reset2");
    send_pkt(C_FLAGS_REG, 3, 16'h0105, 16'h0106, 16'h0107, 1'b1);
    send_pkt(C_FLAGS_FI, 1, 16'h0280, 16'h0, 16'h0, 1'b1);
    settle("b2b");

    // Reset arriving with an output pulse already registered
    send_pkt(C_FLAGS_FI, 1, 16'h0505, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.debug_in_valid = 1'b0;
    bus.debug_in_last  = 1'b0;
    @(negedge clk);
    chk("suppress_valid", {15'd0, bus.fi_valid}, 16'd0);
    do_reset("reset3");

    // Reset mid-packet after the flags word, then a fresh command
    put(16'h0011, 1'b0);
    put(16'h0022, 1'b0);
    put(C_FLAGS_FI, 1'b0);
    do_reset("abort");
    send_pkt(C_FLAGS_FI, 1, 16'h0101, 16'h0, 16'h0, 1'b1);
    settle("after_abort");

    // Counter saturation
    @(negedge clk);
    force dut.r_cnt_ok = 16'hFFFD;
    #2;
    release dut.r_cnt_ok;
    exp_ok = 16'hFFFD;
    send_pkt(C_FLAGS_FI, 1, 16'h0001, 16'h0, 16'h0, 1'b1);
    send_pkt(C_FLAGS_FI, 1, 16'h0802, 16'h0, 16'h0, 1'b1);
    send_pkt(C_FLAGS_FI, 1, 16'h0304, 16'h0, 16'h0, 1'b1);
    settle("saturate");
    chk("saturate_value", bus.cnt_ok, 16'hFFFF);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
